add_sub: RTL and testbench

//   Rational-number adder/subtractor for the rat datapath. Takes two fractions
//   l_num/l_den and r_num/r_den and produces their unreduced sum or difference:
//   s = (l_num*r_den +/- l_den*r_num) / (l_den*r_den).

---
 rtl/add_sub.sv | 47 ++++
 tb/tb_add_sub.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/add_sub.sv
// Two-stage pipelined rational adder/subtractor: s = (l_num*r_den +/- l_den*r_num) / (l_den*r_den).
// Results are unreduced and wrap modulo 2^WIDTH; one operand set is accepted every clock.
module add_sub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_sub,
    input  logic [WIDTH-1:0] l_num,
    input  logic [WIDTH-1:0] l_den,
    input  logic [WIDTH-1:0] r_num,
    input  logic [WIDTH-1:0] r_den,
    output logic [WIDTH-1:0] s_num,
    output logic [WIDTH-1:0] s_den,
    output logic             rdy
);

    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] pd;
    logic             sub_q;
    logic [1:0]       valid;

    // Only an explicit 0 resets; X or Z on rst falls through to normal operation.
    always_ff @(posedge clk) begin
        if (rst == 1'b0) begin
            p0    <= '0;
            p1    <= '0;
            pd    <= '0;
            sub_q <= 1'b0;
            s_num <= '0;
            s_den <= '0;
            valid <= 2'b00;
        end else begin
            p0    <= l_num * r_den;
            p1    <= l_den * r_num;
            pd    <= l_den * r_den;
            sub_q <= enable_sub;
            s_num <= sub_q ? (p0 - p1) : (p0 + p1);
            s_den <= pd;
            valid <= {valid[0], 1'b1};
        end
    end

    assign rdy = valid[1];

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub: randomized stream compared every cycle against a
// behavioural model, plus hand-computed literal cases that pin the model.
module tb_add_sub;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             enable_sub;
    logic [WIDTH-1:0] l_num;
    logic [WIDTH-1:0] l_den;
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH-1:0] s_num;
    logic [WIDTH-1:0] s_den;
    logic             rdy;

    int total = 0;
    int bad   = 0;

    add_sub #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_sub (enable_sub),
        .l_num      (l_num),
        .l_den      (l_den),
        .r_num      (r_num),
        .r_den      (r_den),
        .s_num      (s_num),
        .s_den      (s_den),
        .rdy        (rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        bad   = bad + 1;
        total = total + 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Full-precision arithmetic, then reduce modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] model_num(input logic [WIDTH-1:0] ln, input logic [WIDTH-1:0] ld,
                                                   input logic [WIDTH-1:0] rn, input logic [WIDTH-1:0] rd,
                                                   input logic sub);
        logic [2*WIDTH+1:0] a;
        logic [2*WIDTH+1:0] b;
        logic [2*WIDTH+1:0] r;
        a = {{(WIDTH+2){1'b0}}, ln} * {{(WIDTH+2){1'b0}}, rd};
        b = {{(WIDTH+2){1'b0}}, ld} * {{(WIDTH+2){1'b0}}, rn};
        r = sub ? (a - b) : (a + b);
        return r[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] model_den(input logic [WIDTH-1:0] ld, input logic [WIDTH-1:0] rd);
        logic [2*WIDTH-1:0] r;
        r = {{WIDTH{1'b0}}, ld} * {{WIDTH{1'b0}}, rd};
        return r[WIDTH-1:0];
    endfunction

    // Output after edge N depends on rst at edges N and N-1 and the inputs seen at edge N-1.
    bit               known     = 1'b0;
    bit               prev_run  = 1'b0;
    logic [WIDTH-1:0] prev_ln, prev_ld, prev_rn, prev_rd;
    logic             prev_sub;

    always @(posedge clk) begin
        logic             cur_run;
        logic [WIDTH-1:0] cur_ln, cur_ld, cur_rn, cur_rd;
        logic             cur_sub;
        logic [WIDTH-1:0] exp_num, exp_den;
        logic             exp_rdy;
        cur_run = (rst !== 1'b0);
        cur_ln  = l_num;
        cur_ld  = l_den;
        cur_rn  = r_num;
        cur_rd  = r_den;
        cur_sub = enable_sub;
        #1;
        if (!cur_run) begin
            known = 1'b1;
        end
        if (known) begin
            if (cur_run && prev_run) begin
                exp_num = model_num(prev_ln, prev_ld, prev_rn, prev_rd, prev_sub);
                exp_den = model_den(prev_ld, prev_rd);
                exp_rdy = 1'b1;
            end else begin
                exp_num = '0;
                exp_den = '0;
                exp_rdy = 1'b0;
            end
            check("model_s_num", s_num, exp_num);
            check("model_s_den", s_den, exp_den);
            check("model_rdy", {31'd0, rdy}, {31'd0, exp_rdy});
        end
        prev_run = cur_run;
        prev_ln  = cur_ln;
        prev_ld  = cur_ld;
        prev_rn  = cur_rn;
        prev_rd  = cur_rd;
        prev_sub = cur_sub;
    end

    task automatic apply_stimulus(input logic [WIDTH-1:0] ln, input logic [WIDTH-1:0] ld,
                                  input logic [WIDTH-1:0] rn, input logic [WIDTH-1:0] rd,
                                  input logic sub);
        @(negedge clk);
        l_num      = ln;
        l_den      = ld;
        r_num      = rn;
        r_den      = rd;
        enable_sub = sub;
    endtask

    task automatic check_output(input string name, input logic [WIDTH-1:0] ln, input logic [WIDTH-1:0] ld,
                                input logic [WIDTH-1:0] rn, input logic [WIDTH-1:0] rd, input logic sub,
                                input logic [WIDTH-1:0] exp_num, input logic [WIDTH-1:0] exp_den);
        apply_stimulus(ln, ld, rn, rd, sub);
        @(posedge clk);
        @(posedge clk);
        #2;
        check({name, "_num"}, s_num, exp_num);
        check({name, "_den"}, s_den, exp_den);
        check({name, "_rdy"}, {31'd0, rdy}, 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        enable_sub = 1'b0;
        l_num      = '0;
        l_den      = '0;
        r_num      = '0;
        r_den      = '0;

        repeat (2) @(posedge clk);
        #2;
        check("reset_s_num", s_num, 32'd0);
        check("reset_s_den", s_den, 32'd0);
        check("reset_rdy", {31'd0, rdy}, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("release_rdy_edge1", {31'd0, rdy}, 32'd0);
        @(posedge clk);
        #2;
        check("release_rdy_edge2", {31'd0, rdy}, 32'd1);

        check_output("add",  32'd1, 32'd2, 32'd1, 32'd3, 1'b0, 32'd5, 32'd6);
        check_output("sub",  32'd3, 32'd4, 32'd1, 32'd2, 1'b1, 32'd2, 32'd8);
        check_output("neg",  32'd1, 32'd2, 32'd3, 32'd4, 1'b1, 32'hFFFF_FFFE, 32'd8);
        check_output("wrap", 32'h1_0000, 32'h1_0000, 32'd0, 32'h1_0000, 1'b0, 32'd0, 32'd0);
        check_output("maxv", 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd3, 1'b0, 32'hFFFF_FFFF, 32'd6);
        check_output("zden", 32'd7, 32'd0, 32'd5, 32'd9, 1'b1, 32'd63, 32'd0);

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(32'($urandom_range(999)), 32'($urandom_range(999)),
                           32'($urandom_range(999)), 32'($urandom_range(999)), 1'($urandom_range(1)));
            if (i == 12) begin
                rst = 1'b0;
                @(posedge clk);
                #2;
                check("midreset_s_num", s_num, 32'd0);
                check("midreset_s_den", s_den, 32'd0);
                check("midreset_rdy", {31'd0, rdy}, 32'd0);
            end else begin
                rst = 1'b1;
            end
        end

        for (int i = 0; i < 30; i++) begin
            apply_stimulus($urandom, $urandom, $urandom, $urandom, 1'($urandom_range(1)));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
